ring_inject_arb: RTL

Request-ring injection arbiter inside a tile's ring controller. It shares the tile's outgoing request-ring slot between transit traffic and up to four local requesters (hardware threads). Transit traffic always has priority; local requests are injected round-robin into free slots only. The output is registered, giving one pipeline stage between ring-in (Q500H) and ring-out (Q501H).

---
 rtl/lotr_pkg.sv | 26 ++
 rtl/ring_inject_arb_if.sv | 52 +++++
 rtl/ring_inject_arb.sv | 127 ++++++++++++
 3 files changed

// File: rtl/lotr_pkg.sv
// Shared ring types for the tile's request ring.
//   t_opcode    : ring opcode encoding
//   t_ring_slot : one request-ring slot (valid, requestor, opcode, address, data)
package lotr_pkg;

    localparam int unsigned OPCODE_W    = 4;
    localparam int unsigned REQUESTOR_W = 10;
    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned DATA_W      = 32;

    typedef logic [OPCODE_W-1:0] t_opcode;

    localparam t_opcode OP_NOP   = 4'h0;
    localparam t_opcode OP_READ  = 4'h1;
    localparam t_opcode OP_WRITE = 4'h2;
    localparam t_opcode OP_ATOM  = 4'h3;

    typedef struct packed {
        logic                   valid;
        logic [REQUESTOR_W-1:0] requestor;
        t_opcode                opcode;
        logic [ADDR_W-1:0]      address;
        logic [DATA_W-1:0]      data;
    } t_ring_slot;

endpackage

// File: rtl/ring_inject_arb_if.sv
// Bus bundle for ring_inject_arb: incoming ring slot, local requesters,
// outgoing ring slot and status.
//   master : drives ring-in and requests, observes grants, ring-out, status
//   slave  : the arbiter side
interface ring_inject_arb_if
    import lotr_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
);
    // Ring in (Q500H)
    logic                              RingInValidQ500H;
    logic [REQUESTOR_W-1:0]            RingInRequestorQ500H;
    t_opcode                           RingInOpcodeQ500H;
    logic [ADDR_W-1:0]                 RingInAddressQ500H;
    logic [DATA_W-1:0]                 RingInDataQ500H;
    logic                              LocalConsumeQ500H;

    // Local requesters (Q500H)
    logic [NUM_REQ-1:0]                ReqValidQ500H;
    t_opcode [NUM_REQ-1:0]             ReqOpcodeQ500H;
    logic [NUM_REQ-1:0][ADDR_W-1:0]    ReqAddressQ500H;
    logic [NUM_REQ-1:0][DATA_W-1:0]    ReqDataQ500H;
    logic [NUM_REQ-1:0]                ReqReadyQ500H;

    // Ring out and status (Q501H)
    logic                              RingOutValidQ501H;
    logic [REQUESTOR_W-1:0]            RingOutRequestorQ501H;
    t_opcode                           RingOutOpcodeQ501H;
    logic [ADDR_W-1:0]                 RingOutAddressQ501H;
    logic [DATA_W-1:0]                 RingOutDataQ501H;
    logic [NUM_REQ-1:0]                StarveQ501H;
    logic [15:0]                       InjCntQ501H;

    modport master (
        output RingInValidQ500H, RingInRequestorQ500H, RingInOpcodeQ500H,
               RingInAddressQ500H, RingInDataQ500H, LocalConsumeQ500H,
               ReqValidQ500H, ReqOpcodeQ500H, ReqAddressQ500H, ReqDataQ500H,
        input  ReqReadyQ500H, RingOutValidQ501H, RingOutRequestorQ501H,
               RingOutOpcodeQ501H, RingOutAddressQ501H, RingOutDataQ501H,
               StarveQ501H, InjCntQ501H
    );

    modport slave (
        input  RingInValidQ500H, RingInRequestorQ500H, RingInOpcodeQ500H,
               RingInAddressQ500H, RingInDataQ500H, LocalConsumeQ500H,
               ReqValidQ500H, ReqOpcodeQ500H, ReqAddressQ500H, ReqDataQ500H,
        output ReqReadyQ500H, RingOutValidQ501H, RingOutRequestorQ501H,
               RingOutOpcodeQ501H, RingOutAddressQ501H, RingOutDataQ501H,
               StarveQ501H, InjCntQ501H
    );

endinterface

// File: rtl/ring_inject_arb.sv
// Request-ring injection arbiter. Transit traffic owns the outgoing slot;
// local requesters are injected round-robin into free slots (empty or
// consumed by this tile). One register stage from ring-in to ring-out.
// Ports:
//   QClk     : clock, rising edge
//   RstQnnnH : asynchronous active-high reset
//   CoreID   : tile ID, upper bits of injected requestor field
//   bus      : ring_inject_arb_if.slave (ring in/out, requests, grants, status)
module ring_inject_arb
    import lotr_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WAIT_W  = 8
) (
    input  logic              QClk,
    input  logic              RstQnnnH,
    input  logic [7:0]        CoreID,
    ring_inject_arb_if.slave  bus
);

    localparam int unsigned    IDX_W    = 2;
    localparam int unsigned    SCAN_W   = 3;
    localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

    t_ring_slot                     slot_q, slot_d;
    logic [IDX_W-1:0]               rr_ptr_q, rr_ptr_d;
    logic [15:0]                    inj_cnt_q, inj_cnt_d;
    logic [NUM_REQ-1:0][WAIT_W-1:0] wait_q, wait_d;
    logic [NUM_REQ-1:0]             starve_q, starve_d;

    logic                           slot_free_c;
    logic                           grant_vld_c;
    logic [IDX_W-1:0]               grant_idx_c;
    logic [SCAN_W-1:0]              scan_c;
    logic [SCAN_W-1:0]              ptr_nxt_c;
    logic [NUM_REQ-1:0]             ready_c;

    // Round-robin search upward from rr_ptr_q, only when the slot is free
    always_comb begin
        slot_free_c = !bus.RingInValidQ500H || bus.LocalConsumeQ500H;
        grant_vld_c = 1'b0;
        grant_idx_c = '0;
        scan_c      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_c = SCAN_W'(rr_ptr_q) + SCAN_W'(k);
            if (scan_c >= SCAN_W'(NUM_REQ)) begin
                scan_c = scan_c - SCAN_W'(NUM_REQ);
            end
            if (!grant_vld_c && bus.ReqValidQ500H[scan_c[IDX_W-1:0]]) begin
                grant_vld_c = 1'b1;
                grant_idx_c = scan_c[IDX_W-1:0];
            end
        end
        // No grants while the ring is occupied or the block is in reset
        if (!slot_free_c || RstQnnnH) begin
            grant_vld_c = 1'b0;
        end
        ready_c = grant_vld_c ? (NUM_REQ'(1) << grant_idx_c) : '0;
    end

    assign bus.ReqReadyQ500H = ready_c;

    // Next outgoing slot, pointer and injection count
    always_comb begin
        slot_d    = '0;
        rr_ptr_d  = rr_ptr_q;
        inj_cnt_d = inj_cnt_q;
        ptr_nxt_c = SCAN_W'(grant_idx_c) + SCAN_W'(1);
        if (ptr_nxt_c >= SCAN_W'(NUM_REQ)) begin
            ptr_nxt_c = '0;
        end
        if (!slot_free_c) begin
            slot_d.valid     = 1'b1;
            slot_d.requestor = bus.RingInRequestorQ500H;
            slot_d.opcode    = bus.RingInOpcodeQ500H;
            slot_d.address   = bus.RingInAddressQ500H;
            slot_d.data      = bus.RingInDataQ500H;
        end else if (grant_vld_c) begin
            slot_d.valid     = 1'b1;
            slot_d.requestor = {CoreID, grant_idx_c};
            slot_d.opcode    = bus.ReqOpcodeQ500H[grant_idx_c];
            slot_d.address   = bus.ReqAddressQ500H[grant_idx_c];
            slot_d.data      = bus.ReqDataQ500H[grant_idx_c];
            rr_ptr_d         = ptr_nxt_c[IDX_W-1:0];
            inj_cnt_d        = inj_cnt_q + 16'd1;
        end
    end

    // Per-requester saturating wait counters; starve tracks the next value
    always_comb begin
        wait_d   = wait_q;
        starve_d = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!bus.ReqValidQ500H[i] || ready_c[i]) begin
                wait_d[i] = '0;
            end else if (wait_q[i] != WAIT_MAX) begin
                wait_d[i] = wait_q[i] + WAIT_W'(1);
            end
            starve_d[i] = (wait_d[i] == WAIT_MAX);
        end
    end

    always_ff @(posedge QClk or posedge RstQnnnH) begin
        if (RstQnnnH) begin
            slot_q    <= '0;
            rr_ptr_q  <= '0;
            inj_cnt_q <= '0;
            wait_q    <= '0;
            starve_q  <= '0;
        end else begin
            slot_q    <= slot_d;
            rr_ptr_q  <= rr_ptr_d;
            inj_cnt_q <= inj_cnt_d;
            wait_q    <= wait_d;
            starve_q  <= starve_d;
        end
    end

    assign bus.RingOutValidQ501H     = slot_q.valid;
    assign bus.RingOutRequestorQ501H = slot_q.requestor;
    assign bus.RingOutOpcodeQ501H    = slot_q.opcode;
    assign bus.RingOutAddressQ501H   = slot_q.address;
    assign bus.RingOutDataQ501H      = slot_q.data;
    assign bus.StarveQ501H           = starve_q;
    assign bus.InjCntQ501H           = inj_cnt_q;

endmodule
